// File: rtl/imm_extend_pipe.sv
// Immediate extraction and extension for RISC-V and ARM instruction words,
// followed by an elastic register pipeline of STAGES slices.
module imm_extend_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_arm,
  input  logic [31:0]     in_instr,
  input  logic [2:0]      in_immsrc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_immext,
  output logic            out_illegal,
  output logic [15:0]     ill_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; the item is held stable on the outputs while valid=1 and ready=0.

  logic [31:0]     raw32;
  logic            raw_sign;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_imm;
  logic [63:0]     rot_dbl;
  logic [4:0]      rot_amt;

  // raw32 already carries the 32-bit extension; raw_sign widens it to XLEN.
  always_comb begin
    raw32       = '0;
    raw_sign    = 1'b0;
    dec_illegal = 1'b0;
    rot_amt     = {in_instr[11:8], 1'b0};
    rot_dbl     = {2{24'b0, in_instr[7:0]}} >> rot_amt;
    if (!in_arm) begin
      case (in_immsrc)
        3'b000: begin
          raw32    = {{20{in_instr[31]}}, in_instr[31:20]};
          raw_sign = in_instr[31];
        end
        3'b001: begin
          raw32    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
          raw_sign = in_instr[31];
        end
        3'b010: begin
          raw32    = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
          raw_sign = in_instr[31];
        end
        3'b011: begin
          raw32    = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
          raw_sign = in_instr[31];
        end
        3'b100: begin
          raw32    = {in_instr[31:12], 12'b0};
          raw_sign = in_instr[31];
        end
        3'b101:  raw32 = {27'b0, in_instr[19:15]};
        default: dec_illegal = 1'b1;
      endcase
    end else begin
      case (in_immsrc)
        3'b000: raw32 = {24'b0, in_instr[7:0]};
        3'b001: raw32 = {20'b0, in_instr[11:0]};
        3'b010: begin
          raw32    = {{6{in_instr[23]}}, in_instr[23:0], 2'b00};
          raw_sign = in_instr[23];
        end
        3'b011:  raw32 = rot_dbl[31:0];
        3'b100:  raw32 = {16'b0, in_instr[19:16], in_instr[11:0]};
        default: dec_illegal = 1'b1;
      endcase
    end
    dec_imm = XLEN'(raw32) | (raw_sign ? ~XLEN'(32'hFFFF_FFFF) : '0);
  end

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] ill_q;
  logic [XLEN-1:0]   imm_q [STAGES];
  logic [STAGES-1:0] load;
  logic              accept;

  // A slice may load when it, or any slice downstream of it, has a free spot,
  // or when the last slice is draining this cycle.
  always_comb begin
    load = '0;
    for (int k = 0; k < STAGES; k++) begin
      load[k] = out_ready;
      for (int j = 0; j < STAGES; j++) begin
        if (j >= k && !valid_q[j]) load[k] = 1'b1;
      end
    end
  end

  assign in_ready = load[0] && !flush && !reset;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      ill_q   <= '0;
      for (int k = 0; k < STAGES; k++) imm_q[k] <= '0;
    end else begin
      if (load[0]) begin
        valid_q[0] <= accept;
        if (accept) begin
          imm_q[0] <= dec_imm;
          ill_q[0] <= dec_illegal;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (load[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) begin
            imm_q[k] <= imm_q[k-1];
            ill_q[k] <= ill_q[k-1];
          end
        end
      end
      if (flush) valid_q <= '0;
    end
  end

  assign out_valid   = valid_q[STAGES-1];
  assign out_immext  = imm_q[STAGES-1];
  assign out_illegal = ill_q[STAGES-1];

  // A delivery that coincides with flush still counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      ill_count <= '0;
    end else if (out_valid && out_ready && out_illegal && ill_count != 16'hFFFF) begin
      ill_count <= ill_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: a 32-bit single-slice and a 64-bit two-slice instance
// share the input stream, each checked every cycle against a timestamp-queue model.
module tb_imm_extend_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, in_arm;
  logic [31:0] in_instr;
  logic [2:0]  in_immsrc;
  logic        rdy_a, rdy_b;

  logic        in_ready_a, out_valid_a, out_illegal_a;
  logic [31:0] out_immext_a;
  logic [15:0] ill_count_a;
  logic        in_ready_b, out_valid_b, out_illegal_b;
  logic [63:0] out_immext_b;
  logic [15:0] ill_count_b;

  imm_extend_pipe #(.XLEN(32), .STAGES(1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_arm(in_arm), .in_instr(in_instr), .in_immsrc(in_immsrc), .out_valid(out_valid_a),
    .out_ready(rdy_a), .out_immext(out_immext_a), .out_illegal(out_illegal_a),
    .ill_count(ill_count_a)
  );

  imm_extend_pipe #(.XLEN(64), .STAGES(2)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_arm(in_arm), .in_instr(in_instr), .in_immsrc(in_immsrc), .out_valid(out_valid_b),
    .out_ready(rdy_b), .out_immext(out_immext_b), .out_illegal(out_illegal_b),
    .ill_count(ill_count_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference decode: pick the immediate field, then extend it arithmetically.
  function automatic void ref_imm(input logic arm, input logic [31:0] ins, input logic [2:0] src,
                                  input int xlen, output logic [63:0] imm, output logic ill);
    longint      val;
    int          w;
    int          n;
    logic        sext;
    logic [31:0] r;
    val  = 0;
    w    = 1;
    sext = 1'b0;
    ill  = 1'b0;
    if (!arm) begin
      case (src)
        3'd0: begin val = longint'(ins[31:20]); w = 12; sext = 1'b1; end
        3'd1: begin val = longint'({ins[31:25], ins[11:7]}); w = 12; sext = 1'b1; end
        3'd2: begin val = longint'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); w = 13; sext = 1'b1; end
        3'd3: begin val = longint'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); w = 21; sext = 1'b1; end
        3'd4: begin val = longint'({ins[31:12], 12'b0}); w = 32; sext = 1'b1; end
        3'd5: val = longint'(ins[19:15]);
        default: ill = 1'b1;
      endcase
    end else begin
      case (src)
        3'd0: val = longint'(ins[7:0]);
        3'd1: val = longint'(ins[11:0]);
        3'd2: begin val = longint'({ins[23:0], 2'b00}); w = 26; sext = 1'b1; end
        3'd3: begin
          r = {24'b0, ins[7:0]};
          n = 2 * int'(ins[11:8]);
          for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
          val = longint'(r);
        end
        3'd4: val = longint'({ins[19:16], ins[11:0]});
        default: ill = 1'b1;
      endcase
    end
    if (sext && val >= (longint'(1) << (w - 1))) val = val - (longint'(1) << w);
    imm = 64'(val);
    if (xlen == 32) imm = imm & 64'h0000_0000_FFFF_FFFF;
  endfunction

  // Model: each instance is a FIFO of capacity STAGES; an item may appear at the
  // output STAGES cycles after acceptance and no earlier than the cycle after its
  // predecessor left.
  int          stg [2] = '{1, 2};
  int          xl  [2] = '{32, 64};
  logic [63:0] m_imm [2][8];
  logic        m_ill [2][8];
  int          m_acc [2][8];
  int          m_head [2] = '{0, 0};
  int          m_cnt  [2] = '{0, 0};
  int          m_last [2] = '{-100, -100};
  int          m_illcnt [2] = '{0, 0};
  int          cyc = 0;
  logic        model_on = 1'b0;
  logic        cap_b = 1'b0;
  logic [63:0] got_b [$];

  always @(negedge clk) begin
    if (model_on) begin
      for (int d = 0; d < 2; d++) begin : per_dut
        logic        ordy, m_rdy, m_ov, e_ill;
        logic [63:0] e_imm;
        int          h, slot;
        string       nm;
        nm   = (d == 0) ? "a" : "b";
        ordy = (d == 0) ? rdy_a : rdy_b;
        h    = m_head[d];
        m_rdy = !reset && !flush && (m_cnt[d] < stg[d] || ordy);
        m_ov  = m_cnt[d] > 0 && cyc >= m_acc[d][h] + stg[d] && cyc >= m_last[d] + 1;
        chk({nm, " in_ready"}, 64'((d == 0) ? in_ready_a : in_ready_b), 64'(m_rdy));
        chk({nm, " out_valid"}, 64'((d == 0) ? out_valid_a : out_valid_b), 64'(m_ov));
        if (m_ov) begin
          chk({nm, " out_immext"}, (d == 0) ? {32'b0, out_immext_a} : out_immext_b, m_imm[d][h]);
          chk({nm, " out_illegal"}, 64'((d == 0) ? out_illegal_a : out_illegal_b), 64'(m_ill[d][h]));
        end
        chk({nm, " ill_count"}, 64'((d == 0) ? ill_count_a : ill_count_b), 64'(m_illcnt[d]));
        if (reset) begin
          m_cnt[d]    = 0;
          m_illcnt[d] = 0;
          m_last[d]   = -100;
        end else begin
          if (m_ov && ordy) begin
            if (m_ill[d][h] && m_illcnt[d] < 65535) m_illcnt[d]++;
            m_head[d] = (h + 1) % 8;
            m_cnt[d]--;
            m_last[d] = cyc;
          end
          if (flush) begin
            m_cnt[d] = 0;
          end else if (in_valid && m_rdy && m_cnt[d] < 8) begin
            slot = (m_head[d] + m_cnt[d]) % 8;
            ref_imm(in_arm, in_instr, in_immsrc, xl[d], e_imm, e_ill);
            m_imm[d][slot] = e_imm;
            m_ill[d][slot] = e_ill;
            m_acc[d][slot] = cyc;
            m_cnt[d]++;
          end
        end
      end
      if (cap_b && out_valid_b && rdy_b) got_b.push_back(out_immext_b);
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic arm, input logic [31:0] ins, input logic [2:0] src);
    in_valid  = v;
    in_arm    = arm;
    in_instr  = ins;
    in_immsrc = src;
  endtask

  initial begin : stim
    int          k;
    logic        arm;
    logic [63:0] e_imm;
    logic        e_ill;
    reset = 1'b1;
    flush = 1'b0;
    rdy_a = 1'b1;
    rdy_b = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 3'd0);
    tick();
    model_on = 1'b1;
    settle();
    chk("reset in_ready a", 64'(in_ready_a), 64'd0);
    chk("reset in_ready b", 64'(in_ready_b), 64'd0);
    tick();
    reset = 1'b0;
    settle();
    chk("post-reset in_ready a", 64'(in_ready_a), 64'd1);
    chk("post-reset in_ready b", 64'(in_ready_b), 64'd1);
    chk("post-reset out_valid b", 64'(out_valid_b), 64'd0);
    chk("post-reset immext a", {32'b0, out_immext_a}, 64'd0);
    chk("post-reset immext b", out_immext_b, 64'd0);

    // Pin the reference decode itself.
    ref_imm(1'b0, 32'hFFF0_0093, 3'd0, 32, e_imm, e_ill);
    chk("model I", e_imm, 64'h0000_0000_FFFF_FFFF);
    ref_imm(1'b1, 32'hE3A0_04FF, 3'd3, 64, e_imm, e_ill);
    chk("model ARM rot", e_imm, 64'h0000_0000_FF00_0000);
    ref_imm(1'b0, 32'h8000_00B7, 3'd4, 64, e_imm, e_ill);
    chk("model U", e_imm, 64'hFFFF_FFFF_8000_0000);
    ref_imm(1'b1, 32'h0000_0000, 3'd6, 64, e_imm, e_ill);
    chk("model ARM illegal", 64'(e_ill), 64'd1);

    // Single I-type item; one-cycle and two-cycle latencies.
    drive(1'b1, 1'b0, 32'hFFF0_0093, 3'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 3'd0);
    settle();
    chk("I out_valid a", 64'(out_valid_a), 64'd1);
    chk("I immext a", {32'b0, out_immext_a}, 64'h0000_0000_FFFF_FFFF);
    chk("I illegal a", 64'(out_illegal_a), 64'd0);
    chk("I out_valid b early", 64'(out_valid_b), 64'd0);
    tick();
    settle();
    chk("I out_valid b", 64'(out_valid_b), 64'd1);
    chk("I immext b", out_immext_b, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();

    // ARM rotated immediate then RISC-V U-type, back to back.
    drive(1'b1, 1'b1, 32'hE3A0_04FF, 3'd3);
    tick();
    drive(1'b1, 1'b0, 32'h8000_00B7, 3'd4);
    settle();
    chk("rot immext a", {32'b0, out_immext_a}, 64'h0000_0000_FF00_0000);
    tick();
    drive(1'b0, 1'b0, 32'h0, 3'd0);
    settle();
    chk("rot immext b", out_immext_b, 64'h0000_0000_FF00_0000);
    chk("U immext a", {32'b0, out_immext_a}, 64'h0000_0000_8000_0000);
    tick();
    settle();
    chk("U immext b", out_immext_b, 64'hFFFF_FFFF_8000_0000);
    tick();
    tick();

    // Four items into the two-slice instance with a three-cycle downstream stall.
    cap_b = 1'b1;
    got_b.delete();
    k = 0;
    for (int c = 0; c < 16; c++) begin
      rdy_b = !(c >= 2 && c <= 4);
      if (k < 4) drive(1'b1, 1'b0, {12'(k + 1), 20'h0}, 3'd0);
      else       drive(1'b0, 1'b0, 32'h0, 3'd0);
      settle();
      if (c == 2) chk("stall in_ready b", 64'(in_ready_b), 64'd0);
      if (k < 4 && in_ready_b) k++;
      tick();
    end
    cap_b = 1'b0;
    rdy_b = 1'b1;
    chk("stall delivered count", 64'(got_b.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_b.size()) chk("stall order", got_b[i], 64'(i + 1));
    end

    // Fill both slices, flush, then check the next item's latency.
    rdy_b = 1'b0;
    drive(1'b1, 1'b0, {12'h0AA, 20'h0}, 3'd0);
    tick();
    drive(1'b1, 1'b0, {12'h0BB, 20'h0}, 3'd0);
    tick();
    drive(1'b1, 1'b0, {12'h0CC, 20'h0}, 3'd0);
    flush = 1'b1;
    settle();
    chk("flush in_ready b", 64'(in_ready_b), 64'd0);
    chk("flush in_ready a", 64'(in_ready_a), 64'd0);
    tick();
    flush = 1'b0;
    rdy_b = 1'b1;
    drive(1'b1, 1'b0, {12'h0DD, 20'h0}, 3'd0);
    settle();
    chk("after flush out_valid b", 64'(out_valid_b), 64'd0);
    chk("after flush out_valid a", 64'(out_valid_a), 64'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 3'd0);
    settle();
    chk("flush latency b 1", 64'(out_valid_b), 64'd0);
    tick();
    settle();
    chk("flush latency b 2", 64'(out_valid_b), 64'd1);
    chk("flush item b", out_immext_b, 64'h0000_0000_0000_00DD);
    tick();
    tick();

    // Three illegal RISC-V items, then two illegal ARM items.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, $urandom, 3'd6);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 3'd0);
    settle();
    chk("illegal out_valid a", 64'(out_valid_a), 64'd1);
    chk("illegal immext a", {32'b0, out_immext_a}, 64'd0);
    chk("illegal flag a", 64'(out_illegal_a), 64'd1);
    tick();
    tick();
    tick();
    settle();
    chk("ill_count 3 a", 64'(ill_count_a), 64'd3);
    chk("ill_count 3 b", 64'(ill_count_b), 64'd3);
    drive(1'b1, 1'b1, $urandom, 3'd5);
    tick();
    drive(1'b1, 1'b1, $urandom, 3'd7);
    tick();
    drive(1'b0, 1'b0, 32'h0, 3'd0);
    tick();
    tick();
    tick();
    settle();
    chk("ill_count 5 a", 64'(ill_count_a), 64'd5);
    chk("ill_count 5 b", 64'(ill_count_b), 64'd5);

    // Reset with items in flight.
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    drive(1'b1, 1'b0, 32'h0010_0093, 3'd0);
    tick();
    drive(1'b1, 1'b0, 32'h0020_0093, 3'd0);
    tick();
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 3'd0);
    tick();
    reset = 1'b0;
    settle();
    chk("reset out_valid a", 64'(out_valid_a), 64'd0);
    chk("reset out_valid b", 64'(out_valid_b), 64'd0);
    chk("reset immext a", {32'b0, out_immext_a}, 64'd0);
    chk("reset immext b", out_immext_b, 64'd0);
    chk("reset illegal b", 64'(out_illegal_b), 64'd0);
    chk("reset ill_count a", 64'(ill_count_a), 64'd0);
    chk("reset ill_count b", 64'(ill_count_b), 64'd0);
    rdy_a = 1'b1;
    rdy_b = 1'b1;
    drive(1'b1, 1'b0, 32'h0030_0093, 3'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 3'd0);
    settle();
    chk("first after reset a", {32'b0, out_immext_a}, 64'd3);
    tick();
    settle();
    chk("first after reset b valid", 64'(out_valid_b), 64'd1);
    chk("first after reset b", out_immext_b, 64'd3);
    tick();

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 39) == 0);
      rdy_a = ($urandom_range(0, 3) != 0);
      rdy_b = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)));
      tick();
    end
    reset = 1'b0;
    flush = 1'b0;

    // Saturation of the illegal counter.
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 3'd0);
    tick();
    reset = 1'b0;
    rdy_a = 1'b1;
    rdy_b = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      arm = 1'($urandom_range(0, 1));
      drive(1'b1, arm, $urandom, arm ? 3'($urandom_range(5, 7)) : 3'($urandom_range(6, 7)));
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 3'd0);
    tick();
    tick();
    tick();
    tick();
    settle();
    chk("saturated ill_count a", 64'(ill_count_a), 64'hFFFF);
    chk("saturated ill_count b", 64'(ill_count_b), 64'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32: output immediate width; legal values 32 or 64.
REQ-002 SHALL have parameter STAGES, default 1: number of register slices, legal range 1..4.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous reset, active-high.
REQ-005 SHALL have port flush  input  1: discard all in-flight items.
REQ-006 SHALL have port in_valid  input  1: upstream offers an item.
REQ-007 SHALL have port in_ready  output  1: block accepts the offered item this cycle.
REQ-008 SHALL have port in_arm  input  1: 1 = ARM encoding table, 0 = RISC-V table.
REQ-009 SHALL have port in_instr  input  32: raw instruction word.
REQ-010 SHALL have port in_immsrc  input  3: immediate format select.
REQ-011 SHALL have port out_valid  output  1: item available downstream.
REQ-012 SHALL have port out_ready  input  1: downstream takes the item this cycle.
REQ-013 SHALL have port out_immext  output  XLEN: extended immediate.
REQ-014 SHALL have port out_illegal  output  1: item used an undefined format.
REQ-015 SHALL have port ill_count  output  16: saturating count of illegal items delivered.

Function
REQ-016 RISC-V table (in_arm=0) SHALL be: 000 I {instr[31:20]} sign-ext; 001 S {instr[31:25],instr[11:7]} sign-ext; 010 B {instr[31],instr[7],instr[30:25],instr[11:8],0} sign-ext; 011 J {instr[31],instr[19:12],instr[20],instr[30:21],0} sign-ext; 100 U {instr[31:12],12'b0} sign-ext; 101 CSR zimm instr[19:15] zero-ext.
REQ-017 ARM table (in_arm=1) SHALL be: 000 instr[7:0] zero-ext; 001 instr[11:0] zero-ext; 010 {instr[23:0],00} sign-ext; 011 instr[7:0] rotated right by 2*instr[11:8] within 32 bits, then zero-ext; 100 MOVW {instr[19:16],instr[11:0]} zero-ext.
REQ-018 All extensions SHALL be to XLEN; sign-ext replicates the immediate MSB up to bit XLEN-1.
REQ-019 Undefined selects (RISC-V 110/111, ARM 101-111) SHALL produce immext = 0 and illegal = 1; all defined selects produce illegal = 0.
REQ-020 Immediate and illegal flag SHALL be computed combinationally from the accepted input and captured in slice 1; slices 2..STAGES only delay.
REQ-021 Each slice k SHALL load when its valid bit is 0 or slice k+1 (or, for the last slice, downstream) accepts; otherwise it holds.
REQ-022 in_ready SHALL equal (!valid[1] || slice 1 advances) && !flush && !reset.
REQ-023 Latency SHALL be exactly STAGES cycles from accept to out_valid when out_ready is held high; throughput one item per cycle, with no bubbles inserted under continuous flow.
REQ-024 Items SHALL leave in acceptance order, with no loss or duplication under any out_ready pattern.
REQ-025 out_immext/out_illegal SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 On flush, all valid bits SHALL clear at the next edge; input offered in the flush cycle is not accepted.
REQ-027 An out handshake (out_valid&&out_ready) coinciding with flush SHALL count as delivered.
REQ-028 ill_count SHALL increment by 1 on each delivered item with out_illegal=1 and saturate at 0xFFFF.

Reset
REQ-029 While reset=1, at each edge all valid bits, data registers and ill_count SHALL clear to 0.
REQ-030 After reset: out_valid=0, out_immext=0, out_illegal=0, ill_count=0; in_ready=0 during reset and 1 on the first cycle after.
REQ-031 reset SHALL take priority over flush and over any handshake; in-flight items are dropped and not counted.

Verification
REQ-032 STAGES=1, XLEN=32: in_arm=0, instr 0xFFF00093, immsrc 000 -> one cycle later out_valid=1, out_immext=0xFFFFFFFF, out_illegal=0.
REQ-033 XLEN=64: in_arm=1, instr 0xE3A004FF, immsrc 011 -> out_immext=0x00000000FF000000; RISC-V U instr 0x800000B7, immsrc 100 -> 0xFFFFFFFF80000000.
REQ-034 STAGES=2: stream 4 distinct items with out_ready low for 3 cycles mid-stream -> in_ready drops once both slices are full; all 4 items are delivered in order, each once.
REQ-035 STAGES=2, both slices full, assert flush one cycle -> out_valid=0 next cycle; the flushed items never appear; the next accepted item has latency 2.
REQ-036 Deliver 3 RISC-V immsrc 110 items -> each has out_immext=0, out_illegal=1; ill_count=3; after 65537 illegal deliveries ill_count=0xFFFF.
REQ-037 Assert reset with items in flight and ill_count=5 -> next cycle all outputs are 0; first accept after reset is delivered normally.
